// File: rtl/scalar_mul_ctrl.sv
// scalar_mul_ctrl: bus-facing sequencer for the ScalarMul point-multiplication
// datapath. It loads M, x, y as 12 64-bit words, pulses start, waits for
// finished while counting cycles, then drains X, Y, Z as 12 64-bit words.
//
// Stream handshake: a word moves on a rising edge where valid && ready are
// both high. o_in_ready and o_out_valid are decoded from state alone, so
// neither depends combinationally on the partner's valid or ready. The sender
// keeps data stable while valid is high and ready is low.
module scalar_mul_ctrl #(
  parameter int WORDS = 4,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [63:0]      i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [63:0]      o_out_data,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cycles,
  output logic             o_sm_rst,
  output logic             o_sm_start,
  output logic [254:0]     o_sm_M,
  output logic [254:0]     o_sm_x,
  output logic [254:0]     o_sm_y,
  input  logic [254:0]     i_sm_x,
  input  logic [254:0]     i_sm_y,
  input  logic [254:0]     i_sm_z,
  input  logic             i_sm_finished
);

  // Three operands per direction, WORDS words each.
  localparam int NW = 3 * WORDS;
  localparam logic [3:0] LAST_IDX = 4'(NW - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state, state_next;

  logic [3:0]       in_idx;
  logic [3:0]       out_idx;
  logic             in_fire;
  logic             out_fire;
  logic             in_last;
  logic             out_last;
  logic [254:0]     op_m, op_x, op_y;
  logic [254:0]     res_x, res_y, res_z;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cycles;
  logic [254:0]     sel_res;
  logic [255:0]     sel_ext;
  logic [63:0]      sel_word;

  assign in_fire  = (state == ST_LOAD) && i_in_valid;
  assign out_fire = (state == ST_DRAIN) && i_out_ready;
  assign in_last  = (in_idx == LAST_IDX);
  assign out_last = (out_idx == LAST_IDX);

  // Saturating increment so a hung datapath does not wrap the latency count.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  // The datapath reset simply mirrors our own reset, inverted.
  assign o_sm_rst = ~i_rst_n;
  assign o_sm_M   = op_m;
  assign o_sm_x   = op_x;
  assign o_sm_y   = op_y;
  assign o_cycles = cycles;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_LOAD;
    else          state <= state_next;
  end

  // Next-state logic and state-decoded stream/control outputs.
  always_comb begin
    state_next  = state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_sm_start  = 1'b0;
    o_busy      = 1'b1;
    case (state)
      ST_LOAD: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b0;
        if (in_fire && in_last) state_next = ST_START;
      end
      ST_START: begin
        o_sm_start = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_sm_finished) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_out_valid = 1'b1;
        if (out_fire && out_last) state_next = ST_LOAD;
      end
      default: state_next = ST_LOAD;
    endcase
  end

  // Word indices for the input and output streams, wrapping after 12 words.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_idx  <= 4'd0;
      out_idx <= 4'd0;
    end else begin
      if (in_fire)  in_idx  <= in_last  ? 4'd0 : in_idx + 4'd1;
      if (out_fire) out_idx <= out_last ? 4'd0 : out_idx + 4'd1;
    end
  end

  // Operand registers: each accepted word lands in its slice; bit 63 of the
  // top word of each operand has no home in a 255-bit value and is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_m <= '0;
      op_x <= '0;
      op_y <= '0;
    end else if (in_fire) begin
      case (in_idx)
        4'd0:    op_m[63:0]    <= i_in_data;
        4'd1:    op_m[127:64]  <= i_in_data;
        4'd2:    op_m[191:128] <= i_in_data;
        4'd3:    op_m[254:192] <= i_in_data[62:0];
        4'd4:    op_x[63:0]    <= i_in_data;
        4'd5:    op_x[127:64]  <= i_in_data;
        4'd6:    op_x[191:128] <= i_in_data;
        4'd7:    op_x[254:192] <= i_in_data[62:0];
        4'd8:    op_y[63:0]    <= i_in_data;
        4'd9:    op_y[127:64]  <= i_in_data;
        4'd10:   op_y[191:128] <= i_in_data;
        4'd11:   op_y[254:192] <= i_in_data[62:0];
        default: op_m <= op_m;
      endcase
    end
  end

  // Latency counter plus one-shot capture of results on the first finished
  // seen in WAIT; the captured count includes the capture cycle itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      cycles <= '0;
      res_x  <= '0;
      res_y  <= '0;
      res_z  <= '0;
    end else if (state == ST_START) begin
      cnt <= '0;
    end else if (state == ST_WAIT) begin
      cnt <= cnt_inc;
      if (i_sm_finished) begin
        cycles <= cnt_inc;
        res_x  <= i_sm_x;
        res_y  <= i_sm_y;
        res_z  <= i_sm_z;
      end
    end
  end

  // Output word mux: index bits [3:2] pick X/Y/Z, bits [1:0] pick the word.
  // Zero-extending to 256 bits makes bit 63 of each top word read as 0.
  always_comb begin
    sel_res = res_x;
    case (out_idx[3:2])
      2'd0:    sel_res = res_x;
      2'd1:    sel_res = res_y;
      2'd2:    sel_res = res_z;
      default: sel_res = res_x;
    endcase
    sel_ext  = {1'b0, sel_res};
    sel_word = sel_ext[{out_idx[1:0], 6'b0} +: 64];
    o_out_data = (state == ST_DRAIN) ? sel_word : 64'd0;
  end

endmodule

// File: tb/tb_scalar_mul_ctrl.sv
// Bench for scalar_mul_ctrl with a behavioural stand-in for ScalarMul:
// results are random values the bench chooses, and finished is raised in a
// chosen WAIT cycle.
module tb_scalar_mul_ctrl;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic          busy;
  logic [31:0]   cycles;
  logic          sm_rst;
  logic          sm_start;
  logic [254:0]  sm_m, sm_x, sm_y;
  logic [254:0]  res_x_in, res_y_in, res_z_in;
  logic          sm_finished;

  int            errors = 0;
  int            checks = 0;
  int            start_cnt = 0;
  bit            busy_bad;
  logic [63:0]   exp_q[$];
  logic [63:0]   words[12];

  scalar_mul_ctrl #(.WORDS(4), .CNT_W(32)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_data     (in_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_data    (out_data),
    .o_busy        (busy),
    .o_cycles      (cycles),
    .o_sm_rst      (sm_rst),
    .o_sm_start    (sm_start),
    .o_sm_M        (sm_m),
    .o_sm_x        (sm_x),
    .o_sm_y        (sm_y),
    .i_sm_x        (res_x_in),
    .i_sm_y        (res_y_in),
    .i_sm_z        (res_z_in),
    .i_sm_finished (sm_finished)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Count start pulses as seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n && sm_start === 1'b1) start_cnt++;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: operand g is the little-endian concatenation of its four
  // words, truncated to 255 bits.
  function automatic logic [254:0] pack_op(input logic [63:0] w[12], input int g);
    logic [255:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++) acc = acc | ({192'd0, w[g*4+i]} << (64*i));
    return acc[254:0];
  endfunction

  // Reference: word w of a 255-bit value as seen on a 64-bit bus.
  function automatic logic [63:0] word_of(input logic [254:0] r, input int w);
    logic [255:0] e;
    e = {1'b0, r} >> (64*w);
    return e[63:0];
  endfunction

  function automatic logic [254:0] rand255();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()} >> 1;
  endfunction

  task automatic rand_words();
    for (int i = 0; i < 12; i++) words[i] = {$urandom(), $urandom()};
  endtask

  // ---------------- drivers ----------------
  // Feed 12 words; optional idle cycles between words and a spurious finished
  // pulse during the load. Returns positioned at the START-cycle negedge.
  task automatic load_op(input bit bubbles, input bit spurious);
    int  i;
    int  guard;
    bit  vld;
    i = 0;
    guard = 0;
    while (i < 12 && guard < 200) begin
      @(negedge clk);
      guard++;
      vld = bubbles ? (guard % 2 == 0) : 1'b1;
      in_valid = vld;
      in_data  = vld ? words[i] : {$urandom(), $urandom()};
      sm_finished = spurious && (i == 5);
      if (vld && in_ready) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    sm_finished = 1'b0;
    chk("load_count", i, 12);
    chk("start_latency", sm_start, 1'b1);
  endtask

  // Raise finished in WAIT cycle n with the chosen results; queue the
  // expected output words. Returns positioned at the first DRAIN negedge.
  task automatic run_wait(input int n, input logic [254:0] rx, input logic [254:0] ry,
                          input logic [254:0] rz, input bit hold);
    repeat (n) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_bad = 1'b1;
    end
    res_x_in = rx;
    res_y_in = ry;
    res_z_in = rz;
    sm_finished = 1'b1;
    for (int w = 0; w < 4; w++) exp_q.push_back(word_of(rx, w));
    for (int w = 0; w < 4; w++) exp_q.push_back(word_of(ry, w));
    for (int w = 0; w < 4; w++) exp_q.push_back(word_of(rz, w));
    @(negedge clk);
    chk("valid_latency", out_valid, 1'b1);
    chk("cycles", cycles, n);
    if (hold) begin
      // A re-capture would replace the queued results with these.
      res_x_in = rand255();
      res_y_in = rand255();
      res_z_in = rand255();
    end else begin
      sm_finished = 1'b0;
    end
  endtask

  task automatic drain(input bit bp5, input bit rnd);
    int          got;
    int          guard;
    int          stall;
    logic [63:0] held;
    logic [63:0] e;
    got = 0;
    guard = 0;
    stall = 0;
    held = '0;
    while (got < 12 && guard < 400) begin
      guard++;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (bp5 && got == 5 && stall < 5) begin
        out_ready = 1'b0;
        if (stall == 0) held = out_data;
        stall++;
      end else begin
        if (bp5 && got == 5 && stall == 5) begin
          chk("bp_hold", out_data, held);
          stall++;
        end
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (out_ready && out_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hdead_beef_dead_beef;
        chk($sformatf("out_word%0d", got), out_data, e);
        got++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    sm_finished = 1'b0;
    chk("drain_count", got, 12);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("ready_after_drain", in_ready, 1'b1);
    chk("idle_after_drain", {busy, out_valid}, 2'b00);
  endtask

  // Full transaction against the reference model.
  task automatic txn(input bit bubbles, input bit spurious, input int n,
                     input bit hold, input bit bp5, input bit rnd);
    int s0;
    logic [31:0] cyc_exp;
    s0 = start_cnt;
    busy_bad = 1'b0;
    load_op(bubbles, spurious);
    chk("op_m", sm_m, pack_op(words, 0));
    chk("op_x", sm_x, pack_op(words, 1));
    chk("op_y", sm_y, pack_op(words, 2));
    run_wait(n, rand255(), rand255(), rand255(), hold);
    chk("one_start", start_cnt - s0, 1);
    drain(bp5, rnd);
    cyc_exp = n;
    chk("cycles_held", cycles, cyc_exp);
    chk("busy_through", busy_bad, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    sm_finished = 1'b0;
    res_x_in = '0;
    res_y_in = '0;
    res_z_in = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_start", sm_start, 1'b0);
    chk("rst_ops", {sm_m, sm_x, sm_y} == '0, 1'b1);
    chk("rst_sm_rst", sm_rst, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_sm_rst", sm_rst, 1'b0);

    // Spurious finished in LOAD, 100-cycle latency, backpressure on word 5.
    rand_words();
    txn(1'b0, 1'b1, 100, 1'b0, 1'b1, 1'b0);

    // Top-bit masking with input bubbles, 1-cycle latency, finished held.
    rand_words();
    words[3] = 64'ha59f4329e6f4590b;
    txn(1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    chk("m_top", sm_m[254:192], 63'h259f4329e6f4590b);

    // Reset asserted in WAIT cycle 50.
    rand_words();
    load_op(1'b0, 1'b0);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wrst_busy", busy, 1'b0);
    chk("wrst_in_ready", in_ready, 1'b1);
    chk("wrst_cycles", cycles, 32'd0);
    chk("wrst_ops", {sm_m, sm_x, sm_y} == '0, 1'b1);
    chk("wrst_sm_rst", sm_rst, 1'b1);
    chk("wrst_out", {out_valid, sm_start, out_data}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rand_words();
    txn(1'b0, 1'b0, $urandom_range(1, 20), 1'b0, 1'b0, 1'b0);

    // Random transactions with random output stalls and input bubbles.
    for (int t = 0; t < 4; t++) begin
      rand_words();
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 40),
          1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
